// File: rtl/control_pipe.sv
// control_pipe: D-stage instruction decode feeding X/M/W control registers,
// with BEQ/BNE resolution in X and a multi-cycle MULT sequencer.
package control_pipe_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL
    } t_alu_opcode;

    typedef enum logic [4:0] {
        NEM_ZERO = 5'd0, NEM_ADD, NEM_SUB, NEM_AND, NEM_OR, NEM_XOR, NEM_SLT,
        NEM_SLL, NEM_SRL, NEM_SRA, NEM_MULT, NEM_ADDI, NEM_ADDIU, NEM_BEQ,
        NEM_BNE, NEM_LW, NEM_SW, NEM_J
    } t_instr_pnmen;

    typedef struct packed {
        logic         reg_dst;
        logic         alu_src;
        logic         imm;
        t_alu_opcode  alu;
        logic         mem_read;
        logic         mem_write;
        logic         reg_write;
        logic         mem_to_reg;
        logic         br_eq;
        logic         br_ne;
        logic         is_mult;
        t_instr_pnmen pnem;
    } t_ctl_x;

    typedef struct packed {
        logic         mem_read;
        logic         mem_write;
        logic         reg_write;
        logic         mem_to_reg;
        t_instr_pnmen pnem;
    } t_ctl_m;

    typedef struct packed {
        logic         reg_write;
        logic         mem_to_reg;
        t_instr_pnmen pnem;
    } t_ctl_w;
endpackage

module control_pipe
    import control_pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = $clog2(MUL_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr_D,
    input  logic              stall_D,
    input  logic              zero_X,
    output logic              RegDst_X,
    output logic              ALUSrc_X,
    output logic              Imm_X,
    output t_alu_opcode       alu_control_X,
    output logic              mdu_start_X,
    output logic              MemRead_M,
    output logic              MemWrite_M,
    output logic              RegWrite_M,
    output logic              RegWrite_W,
    output logic              MemToReg_W,
    output logic              Jump_D,
    output logic              branch_taken_X,
    output logic              flush_D,
    output logic              stall_F,
    output logic              mul_busy,
    output t_instr_pnmen      instr_pnem_X,
    output t_instr_pnmen      instr_pnem_M,
    output t_instr_pnmen      instr_pnem_W
);
    typedef enum logic {MUL_IDLE, MUL_BUSY} t_mul_state;

    t_ctl_x     dec_d, ctl_x;
    t_ctl_m     ctl_m;
    t_ctl_w     ctl_w;
    logic       x_new, load_x, r_ok;
    logic [5:0] opcode, funct;
    t_mul_state mul_state, mul_state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_comb begin
        dec_d  = '0;
        Jump_D = 1'b0;
        r_ok   = 1'b0;
        opcode = instr_D[DATA_W-1 -: 6];
        funct  = instr_D[5:0];
        if (instr_D != '0) begin
            case (opcode)
                6'h00: begin
                    r_ok = 1'b1;
                    case (funct)
                        6'h20: begin dec_d.alu = ALU_ADD; dec_d.pnem = NEM_ADD; end
                        6'h22: begin dec_d.alu = ALU_SUB; dec_d.pnem = NEM_SUB; end
                        6'h24: begin dec_d.alu = ALU_AND; dec_d.pnem = NEM_AND; end
                        6'h25: begin dec_d.alu = ALU_OR;  dec_d.pnem = NEM_OR;  end
                        6'h26: begin dec_d.alu = ALU_XOR; dec_d.pnem = NEM_XOR; end
                        6'h2A: begin dec_d.alu = ALU_SLT; dec_d.pnem = NEM_SLT; end
                        6'h00: begin dec_d.alu = ALU_SLL; dec_d.pnem = NEM_SLL; end
                        6'h02: begin dec_d.alu = ALU_SRL; dec_d.pnem = NEM_SRL; end
                        6'h03: begin dec_d.alu = ALU_SRA; dec_d.pnem = NEM_SRA; end
                        6'h18: begin
                            // MULT results go to the MDU, not the register file
                            dec_d.alu     = ALU_MUL;
                            dec_d.pnem    = NEM_MULT;
                            dec_d.is_mult = 1'b1;
                            r_ok          = 1'b0;
                        end
                        default: r_ok = 1'b0;
                    endcase
                    dec_d.reg_dst   = r_ok;
                    dec_d.reg_write = r_ok;
                end
                6'h08, 6'h09: begin
                    dec_d.alu_src   = 1'b1;
                    dec_d.imm       = 1'b1;
                    dec_d.reg_write = 1'b1;
                    dec_d.pnem      = (opcode == 6'h08) ? NEM_ADDI : NEM_ADDIU;
                end
                6'h04: begin dec_d.alu = ALU_SUB; dec_d.br_eq = 1'b1; dec_d.pnem = NEM_BEQ; end
                6'h05: begin dec_d.alu = ALU_SUB; dec_d.br_ne = 1'b1; dec_d.pnem = NEM_BNE; end
                6'h23: begin
                    dec_d.alu_src    = 1'b1;
                    dec_d.mem_read   = 1'b1;
                    dec_d.reg_write  = 1'b1;
                    dec_d.mem_to_reg = 1'b1;
                    dec_d.pnem       = NEM_LW;
                end
                6'h2B: begin
                    dec_d.alu_src   = 1'b1;
                    dec_d.mem_write = 1'b1;
                    dec_d.pnem      = NEM_SW;
                end
                6'h02: begin Jump_D = 1'b1; dec_d.pnem = NEM_J; end
                default: ;
            endcase
        end
    end

    assign branch_taken_X = (ctl_x.br_eq & zero_X) | (ctl_x.br_ne & ~zero_X);
    assign flush_D        = branch_taken_X;
    assign mul_busy       = (mul_state == MUL_BUSY);
    assign stall_F        = stall_D | mul_busy;
    assign load_x         = ~flush_D & ~mul_busy & ~stall_D;

    always_comb begin
        mul_state_nxt = mul_state;
        cnt_nxt       = cnt;
        case (mul_state)
            MUL_IDLE: begin
                if (load_x && dec_d.is_mult && (MUL_CYCLES > 1)) begin
                    mul_state_nxt = MUL_BUSY;
                    cnt_nxt       = CNT_W'(MUL_CYCLES - 1);
                end
            end
            MUL_BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    mul_state_nxt = MUL_IDLE;
                    cnt_nxt       = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_state <= MUL_IDLE;
            cnt       <= '0;
        end else begin
            mul_state <= mul_state_nxt;
            cnt       <= cnt_nxt;
        end
    end

    // x_new marks the first cycle an instruction sits in X, so a held MULT pulses start once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctl_x <= '0;
            ctl_m <= '0;
            ctl_w <= '0;
            x_new <= 1'b0;
        end else begin
            if (flush_D) begin
                ctl_x <= '0;
            end else if (!mul_busy) begin
                if (stall_D) ctl_x <= '0;
                else         ctl_x <= dec_d;
            end
            x_new <= ~mul_busy;
            if (mul_busy) begin
                ctl_m <= '0;
            end else begin
                ctl_m <= '{mem_read: ctl_x.mem_read, mem_write: ctl_x.mem_write,
                           reg_write: ctl_x.reg_write, mem_to_reg: ctl_x.mem_to_reg,
                           pnem: ctl_x.pnem};
            end
            ctl_w <= '{reg_write: ctl_m.reg_write, mem_to_reg: ctl_m.mem_to_reg,
                       pnem: ctl_m.pnem};
        end
    end

    assign RegDst_X      = ctl_x.reg_dst;
    assign ALUSrc_X      = ctl_x.alu_src;
    assign Imm_X         = ctl_x.imm;
    assign alu_control_X = ctl_x.alu;
    assign mdu_start_X   = ctl_x.is_mult & x_new;
    assign instr_pnem_X  = ctl_x.pnem;
    assign MemRead_M     = ctl_m.mem_read;
    assign MemWrite_M    = ctl_m.mem_write;
    assign RegWrite_M    = ctl_m.reg_write;
    assign instr_pnem_M  = ctl_m.pnem;
    assign RegWrite_W    = ctl_w.reg_write;
    assign MemToReg_W    = ctl_w.mem_to_reg;
    assign instr_pnem_W  = ctl_w.pnem;
endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
Parametrised successor to the single-stage decode control. Decodes the D-stage instruction and carries the control bundle and pnemonic through X/M/W pipeline registers, with stall and flush applied at each boundary. Adds BNE alongside BEQ, resolved in X, and a multi-cycle MULT sequencer that freezes the pipe front while busy. Sits between the fetch/decode registers and the datapath; the hazard unit drives stall_D.

Parameters:
DATA_W, 32, instruction width; opcode is [DATA_W-1:DATA_W-6], funct is [5:0]
MUL_CYCLES, 4, total X-stage cycles a MULT occupies; legal range 1..16
CNT_W, $clog2(MUL_CYCLES+1), width of the multiply-sequencer counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
instr_D  in  DATA_W  instruction in decode
stall_D  in  1  hazard stall: hold D, insert bubble into X
zero_X  in  1  ALU zero flag for the instruction in X
RegDst_X/ALUSrc_X/Imm_X  out  1 each  X-stage datapath selects
alu_control_X  out  t_alu_opcode  ALU operation in X
mdu_start_X  out  1  one-cycle pulse: MULT entered X
MemRead_M/MemWrite_M  out  1 each  M-stage memory controls
RegWrite_M  out  1  for forwarding
RegWrite_W/MemToReg_W  out  1 each  writeback controls
Jump_D  out  1  combinational jump request in D
branch_taken_X  out  1  BEQ&zero or BNE&!zero in X
flush_D  out  1  equals branch_taken_X; kills the instruction in D
stall_F  out  1  stall_D | mul_busy; hold PC and F/D
mul_busy  out  1  multiply sequencer active
instr_pnem_X/M/W  out  t_instr_pnmen  per-stage pnemonic

Behaviour:
- Decode (comb, D). R-type funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x2A SLT, 0x00 SLL, 0x02 SRL, 0x03 SRA, 0x18 MULT.
- Opcodes: 0x08 ADDI, 0x09 ADDIU, 0x04 BEQ, 0x05 BNE, 0x23 LW, 0x2B SW, 0x02 J.
- Control values per instruction match the existing control unit. BNE mirrors BEQ (ALU_SUB, branch type NE).
- instr_D == 0 is a NOP: all controls 0, NEM_ZERO. Unknown opcode or funct also decodes as a NOP.
- Bubble: all control bits 0, alu ALU_ADD, NEM_ZERO.
- Reset (rst low, async): every X/M/W register becomes a bubble, the counter clears to 0, and mul_busy=0. All outputs are then 0 or NEM_ZERO.
- D->X update each clock edge, in priority order:
  - flush_D: bubble into X.
  - mul_busy: hold X.
  - stall_D: bubble into X.
  - Otherwise: decoded D into X.
- X->M: bubble while mul_busy; otherwise X moves into M.
- M->W advances every cycle unconditionally.
- Branch resolution: branch_taken_X is combinational from X. The D instruction on that same cycle is flushed (one-cycle penalty). A branch in X never coexists with mul_busy.
- Jump_D is combinational. The F-stage redirect is handled outside this block; no bubble is added here.
- MUL sequencer states: IDLE and BUSY.
  - IDLE->BUSY when MULT latches into X and MUL_CYCLES>1; cnt loads MUL_CYCLES-1.
  - In BUSY, cnt decrements each cycle. BUSY->IDLE when cnt==1 at the clock edge.
  - mul_busy = (state==BUSY), so the MULT stays in X for exactly MUL_CYCLES cycles.
  - MUL_CYCLES==1: no BUSY state; MULT passes through like ADD.
  - mdu_start_X is high only on the first X cycle of each MULT.
- Simultaneous flush and stall: flush wins. stall_D during BUSY has no extra effect.
- Back-to-back MULTs: the second is held in D by stall_F and enters X the cycle after BUSY ends.
- Reset asserted mid-BUSY aborts the sequencer; the MULT is lost.

Test Plan:
- Reset: hold rst=0 with instr_D=0x02328020 (add) -> all outputs 0/NEM_ZERO. After release, add reaches X next edge with RegDst_X=1, alu=ALU_ADD, then RegWrite_M=1, then RegWrite_W=1.
- LW 0x8D090004 then stall_D=1 for 2 cycles -> X holds bubbles for 2 cycles; LW then flows with MemRead_M=1 and MemToReg_W=1.
- BEQ 0x11090003 with zero_X=1 -> branch_taken_X=flush_D=1 for 1 cycle; next X is a bubble. The same test with zero_X=0 -> no flush. BNE 0x15090003 with zero_X=0 -> taken.
- MULT 0x01090018 followed by ADD, MUL_CYCLES=4:
  - mdu_start_X pulses once; mul_busy high 3 cycles; MULT in X for 4 cycles.
  - M receives 3 bubbles; stall_F high 3 cycles; ADD enters X at cycle 5.
  - Repeat with MUL_CYCLES=1 -> no stall.
- Flush and stall together, with stall_D=1 on the same cycle as the branch resolves -> X gets a bubble, no hold, D is flushed.
- Pull rst low during the 2nd BUSY cycle -> mul_busy=0 immediately (async), counter=0. After release, the pipe restarts clean with no residual stall_F.
